// File: rtl/hex_segment_reader_if.sv
// Bus bundle for hex_segment_reader: display-side inputs plus the decoded-frame
// valid/ready handshake toward the consumer.
interface hex_segment_reader_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          HEX_IN;
    logic [DIGITS-1:0]   DIG_SEL;
    logic [4*DIGITS-1:0] VALUE;
    logic [DIGITS-1:0]   ERR_MASK;
    logic                VALID;
    logic                READY;
    logic                OVF;

    modport master (
        output HEX_IN, DIG_SEL, READY,
        input  VALUE, ERR_MASK, VALID, OVF
    );

    modport slave (
        input  HEX_IN, DIG_SEL, READY,
        output VALUE, ERR_MASK, VALID, OVF
    );
endinterface

// File: rtl/hex_segment_reader.sv
// Reads a multiplexed active-low seven-segment bus back into a multi-digit hex word.
// Optional macro HEX_READER_BLANK_EN: pattern 7F decodes as a blank (nibble 0, no error).
module hex_segment_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 8
) (
    input logic             CLOCK_50,
    input logic             RESET,
    hex_segment_reader_if.slave bus
);
    localparam int S_W   = DIGITS + 7;
    localparam int CNT_W = (STABLE > 2) ? $clog2(STABLE) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    // Returns {err, nibble}; unknown patterns give nibble 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:        r = 5'h00;
            7'h5F, 7'h79: r = 5'h01;
            7'h24:        r = 5'h02;
            7'h30:        r = 5'h03;
            7'h19:        r = 5'h04;
            7'h12:        r = 5'h05;
            7'h02:        r = 5'h06;
            7'h78:        r = 5'h07;
            7'h00:        r = 5'h08;
            7'h18:        r = 5'h09;
            7'h08:        r = 5'h0A;
            7'h03:        r = 5'h0B;
            7'h46:        r = 5'h0C;
            7'h21:        r = 5'h0D;
            7'h06:        r = 5'h0E;
            7'h0E:        r = 5'h0F;
`ifdef HEX_READER_BLANK_EN
            7'h7F:        r = 5'h00;
`endif
            default:      r = 5'h10;
        endcase
        return r;
    endfunction

    logic [S_W-1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                taken_q, taken_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [4*DIGITS-1:0] value_q, value_d, shadow_nib_q, shadow_nib_d, merged_nib;
    logic [DIGITS-1:0]   err_q, err_d, shadow_err_q, shadow_err_d, merged_err;
    logic                ovf_q, ovf_d;
    state_t              state_q, state_d;

    logic [DIGITS-1:0]   s_dig;
    logic [6:0]          s_hex;
    logic [4:0]          dec;
    logic                s_change, onehot, capture, frame_done;
    logic                valid, load_frame, ovf_set;

    // Sample path, stability counter and capture decision
    always_comb begin
        sync1_d    = {bus.DIG_SEL, bus.HEX_IN};
        sync2_d    = sync1_q;
        s_dig      = sync2_q[S_W-1:7];
        s_hex      = sync2_q[6:0];
        dec        = decode(s_hex);
        // Looking one stage ahead lets the counter read 0 on the first cycle of a new S.
        s_change   = (sync1_q != sync2_q);
        onehot     = (s_dig != '0) && ((s_dig & (s_dig - DIGITS'(1))) == '0);
        capture    = (cnt_q == CNT_W'(STABLE - 1)) && !taken_q && onehot;
        frame_done = capture && ((seen_q | s_dig) == '1);

        if (s_change)
            cnt_d = '0;
        else if (cnt_q == CNT_W'(STABLE - 1))
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);
        taken_d = s_change ? 1'b0 : (taken_q | capture);
    end

    // Shadow with the current capture merged in, so a completing frame loads in one edge
    always_comb begin
        merged_nib = shadow_nib_q;
        merged_err = shadow_err_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (s_dig[k]) begin
                merged_nib[4*k +: 4] = dec[3:0];
                merged_err[k]        = dec[4];
            end
        end
        shadow_nib_d = capture ? merged_nib : shadow_nib_q;
        shadow_err_d = capture ? merged_err : shadow_err_q;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_done) state_d = HOLD;
                     else if (capture) state_d = COLLECT;
            COLLECT: if (frame_done) state_d = HOLD;
            HOLD:    if (bus.READY && !frame_done) state_d = COLLECT;
            default: state_d = IDLE;
        endcase
    end

    // A completion while the consumer is still busy drops the frame instead of loading it
    always_comb begin
        valid      = (state_q == HOLD);
        load_frame = frame_done && (!valid || bus.READY);
        ovf_set    = frame_done && valid && !bus.READY;
        value_d    = load_frame ? merged_nib : value_q;
        err_d      = load_frame ? merged_err : err_q;
        ovf_d      = ovf_q | ovf_set;
        if (frame_done)
            seen_d = '0;
        else if (capture)
            seen_d = seen_q | s_dig;
        else
            seen_d = seen_q;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            taken_q <= 1'b0;
            seen_q  <= '0;
            value_q <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            seen_q  <= seen_d;
            value_q <= value_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // Shadow contents are only meaningful under seen, so they need no reset
    always_ff @(posedge CLOCK_50) begin
        shadow_nib_q <= shadow_nib_d;
        shadow_err_q <= shadow_err_d;
    end

    assign bus.VALUE    = value_q;
    assign bus.ERR_MASK = err_q;
    assign bus.VALID    = valid;
    assign bus.OVF      = ovf_q;
endmodule

// File: tb/tb_hex_segment_reader.sv
// Directed bench for hex_segment_reader (DIGITS=4, STABLE=8, blank feature off).
module tb_hex_segment_reader;
    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    hex_segment_reader_if #(.DIGITS(4)) hif ();

    hex_segment_reader #(.DIGITS(4), .STABLE(8)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (hif)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] sel, input logic [6:0] pat, input int n);
        hif.DIG_SEL = sel;
        hif.HEX_IN  = pat;
        tick(n);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ready_pulse();
        hif.READY = 1'b1;
        tick(1);
        hif.READY = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        hif.HEX_IN  = 7'h7F;
        hif.DIG_SEL = 4'b0000;
        hif.READY   = 1'b0;
        tick(2);
        check("rst_value", hif.VALUE, 32'h0);
        check("rst_err",   hif.ERR_MASK, 32'h0);
        check("rst_valid", hif.VALID, 32'h0);
        check("rst_ovf",   hif.OVF, 32'h0);
        rst = 1'b0;
        tick(2);

        // Basic scan: digit0..3 show 3,2,1,0
        show(4'b0001, 7'h30, 12);
        show(4'b0010, 7'h24, 12);
        show(4'b0100, 7'h5F, 12);
        show(4'b1000, 7'h40, 9);
        check("scan1_valid_edge9", hif.VALID, 32'h0);
        tick(1);
        check("scan1_valid_edge10", hif.VALID, 32'h1);
        check("scan1_value", hif.VALUE, 32'h0123);
        check("scan1_err", hif.ERR_MASK, 32'h0);
        tick(2);
        check("scan1_valid_held", hif.VALID, 32'h1);
        check("scan1_ovf", hif.OVF, 32'h0);
        ready_pulse();
        check("scan1_valid_drop", hif.VALID, 32'h0);
        check("scan1_value_kept", hif.VALUE, 32'h0123);

        // Glitch: 3-cycle burst of 00 inside digit 1 must not land as 8
        show(4'b0001, 7'h40, 12);
        show(4'b0010, 7'h12, 8);
        show(4'b0010, 7'h00, 3);
        show(4'b0010, 7'h12, 9);
        show(4'b0100, 7'h0E, 12);
        show(4'b1000, 7'h19, 12);
        check("glitch_valid", hif.VALID, 32'h1);
        check("glitch_value", hif.VALUE, 32'h4F50);
        check("glitch_err", hif.ERR_MASK, 32'h0);
        ready_pulse();

        // Invalid pattern on digit 2 and a long multi-hot dwell
        show(4'b1000, 7'h21, 12);
        show(4'b0100, 7'h7F, 12);
        show(4'b0011, 7'h30, 30);
        check("multihot_no_valid", hif.VALID, 32'h0);
        show(4'b0010, 7'h46, 12);
        show(4'b0001, 7'h79, 12);
        check("invalid_valid", hif.VALID, 32'h1);
        check("invalid_value", hif.VALUE, 32'hD0C1);
        check("invalid_err", hif.ERR_MASK, 32'h4);
        ready_pulse();
        check("invalid_valid_drop", hif.VALID, 32'h0);

        // READY coincides with completion of the next frame while in HOLD
        show(4'b0001, 7'h40, 12);
        show(4'b0010, 7'h5F, 12);
        show(4'b0100, 7'h24, 12);
        show(4'b1000, 7'h30, 12);
        check("coin_first_value", hif.VALUE, 32'h3210);
        show(4'b0001, 7'h02, 12);
        show(4'b0010, 7'h78, 12);
        show(4'b0100, 7'h00, 12);
        show(4'b1000, 7'h18, 9);
        check("coin_valid_before", hif.VALID, 32'h1);
        ready_pulse();
        check("coin_valid_stays", hif.VALID, 32'h1);
        check("coin_value", hif.VALUE, 32'h9876);
        check("coin_ovf", hif.OVF, 32'h0);
        ready_pulse();
        check("coin_valid_drop", hif.VALID, 32'h0);

        // Overflow: second frame completes while the first is still pending
        show(4'b0001, 7'h08, 12);
        show(4'b0010, 7'h03, 12);
        show(4'b0100, 7'h06, 12);
        show(4'b1000, 7'h12, 12);
        check("ovf_first_valid", hif.VALID, 32'h1);
        check("ovf_first_value", hif.VALUE, 32'h5EBA);
        check("ovf_not_yet", hif.OVF, 32'h0);
        show(4'b0001, 7'h30, 12);
        show(4'b0010, 7'h24, 12);
        show(4'b0100, 7'h5F, 12);
        show(4'b1000, 7'h40, 12);
        check("ovf_value_held", hif.VALUE, 32'h5EBA);
        check("ovf_set", hif.OVF, 32'h1);
        check("ovf_valid_held", hif.VALID, 32'h1);
        ready_pulse();
        check("ovf_valid_drop", hif.VALID, 32'h0);
        check("ovf_sticky", hif.OVF, 32'h1);

        // Asynchronous reset after two captures, then a clean scan
        show(4'b0001, 7'h19, 12);
        show(4'b0010, 7'h19, 12);
        hif.DIG_SEL = 4'b0000;
        #2 rst = 1'b1;
        #1;
        check("arst_value", hif.VALUE, 32'h0);
        check("arst_err", hif.ERR_MASK, 32'h0);
        check("arst_valid", hif.VALID, 32'h0);
        check("arst_ovf", hif.OVF, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(2);
        show(4'b0100, 7'h24, 12);
        show(4'b1000, 7'h30, 12);
        check("arst_no_stale_frame", hif.VALID, 32'h0);
        show(4'b0001, 7'h5F, 12);
        show(4'b0010, 7'h40, 12);
        check("arst_scan_valid", hif.VALID, 32'h1);
        check("arst_scan_value", hif.VALUE, 32'h3201);
        check("arst_scan_err", hif.ERR_MASK, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
